// File: rtl/tick_timer_arbiter.sv
// Shared prescaled delay timer arbitrated round-robin among four requesters.
// The owner holds the timer for dly ticks and then gets a one-cycle done pulse.
module tick_timer_arbiter #(
  parameter int PRESCALE = 250000,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*CNT_W-1:0] dly,
  output logic [3:0]         grant,
  output logic [3:0]         done,
  output logic               busy,
  output logic               tick
);

  localparam int PW = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [PW-1:0]     presc_q, presc_d;

  logic [1:0]        winner;
  logic [1:0]        cand;
  logic              win_vld;

  // Scan starts after the last granted index; k=4 wraps back to it, so the
  // previous owner is always considered last.
  always_comb begin
    winner  = rr_q;
    cand    = rr_q;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (!win_vld && req[cand]) begin
        winner  = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    tick    = 1'b0;
    grant   = '0;
    done    = '0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (win_vld) begin
          state_d = S_RUN;
          owner_d = winner;
          rr_d    = winner;
          rem_d   = dly[int'(winner)*CNT_W +: CNT_W];
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        grant = 4'b0001 << owner_q;
        tick  = (presc_q == PMAX);
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 4'b0001 << owner_q;
        presc_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= 2'd3;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Scoreboard bench for tick_timer_arbiter (PRESCALE=3): directed stimulus pushes
// expected grant/done/tick events with their cycle; a negedge monitor pops and compares.
module tb_tick_timer_arbiter;

  localparam int CW = 16;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_TICK  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      req = '0;
  logic [4*CW-1:0] dly = '0;
  logic [3:0]      grant, done;
  logic            busy, tick;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_grant = '0;

  tick_timer_arbiter #(.PRESCALE(3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .dly(dly),
    .grant(grant), .done(done), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input int kind, input logic [3:0] val, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [3:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d val=%b at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d val=%b at cycle %0d, expected kind=%0d val=%b at cycle %0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant !== prev_grant) sb_check(EV_GRANT, grant);
      if (done !== 4'b0000) sb_check(EV_DONE, done);
      if (tick !== 1'b0) sb_check(EV_TICK, 4'b0001);
      prev_grant = grant;
      checks++;
      if (busy !== (grant != 4'b0000) || !$onehot0(grant) || !$onehot0(done)) begin
        errors++;
        $display("FAIL invariant: busy=%b grant=%b done=%b at cycle %0d, required busy==|grant and one-hot0",
                 busy, grant, done, cyc);
      end
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL %s: grant=%b done=%b busy=%b tick=%b, required all zero", name, grant, done, busy, tick);
    end
  endtask

  task automatic push_single(input logic [3:0] g, input int gc, input int ndly);
    push(EV_GRANT, g, gc);
    for (int t = 1; t <= ndly; t++) push(EV_TICK, 4'b0001, gc + 4*t - 1);
    push(EV_GRANT, 4'b0000, gc + 4*(ndly == 0 ? 1 : ndly) - (ndly == 0 ? 3 : 0));
    push(EV_DONE, g, gc + (ndly == 0 ? 1 : 4*ndly));
  endtask

  int g;
  int r;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    // Single requester, dly=2: ticks at G+3, G+7, done at G+8.
    dly[0 +: CW] = 16'd2;
    req = 4'b0001;
    g = cyc + 1;
    push_single(4'b0001, g, 2);
    wait_until(g + 8);
    req = '0;
    wait_until(g + 11);

    // All four held with dly=1: rotation 0,1,2,3,0, period 6 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) dly[i*CW +: CW] = 16'd1;
    req = 4'b1111;
    g = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      push(EV_GRANT, oh, g + 6*k);
      push(EV_TICK, 4'b0001, g + 6*k + 3);
      push(EV_GRANT, 4'b0000, g + 6*k + 4);
      push(EV_DONE, oh, g + 6*k + 4);
    end
    wait_until(g + 28);
    req = '0;
    wait_until(g + 32);

    // dly=0: done one cycle after grant, no tick at all.
    do_reset();
    dly[0 +: CW] = 16'd0;
    req = 4'b0001;
    g = cyc + 1;
    push_single(4'b0001, g, 0);
    wait_until(g + 1);
    req = '0;
    wait_until(g + 5);

    // Abort: req0 dropped at G+5, IDLE at G+6, requester 1 granted at G+7.
    do_reset();
    dly[0 +: CW]  = 16'd5;
    dly[CW +: CW] = 16'd1;
    req = 4'b0011;
    g = cyc + 1;
    push(EV_GRANT, 4'b0001, g);
    push(EV_TICK, 4'b0001, g + 3);
    push(EV_GRANT, 4'b0000, g + 6);
    push(EV_GRANT, 4'b0010, g + 7);
    push(EV_TICK, 4'b0001, g + 10);
    push(EV_GRANT, 4'b0000, g + 11);
    push(EV_DONE, 4'b0010, g + 11);
    wait_until(g + 5);
    req = 4'b0010;
    wait_until(g + 11);
    req = '0;
    wait_until(g + 14);

    // Reset mid-RUN clears everything; requester 0 wins first again.
    do_reset();
    dly[0 +: CW]  = 16'd2;
    dly[CW +: CW] = 16'd2;
    req = 4'b0011;
    g = cyc + 1;
    push(EV_GRANT, 4'b0001, g);
    push(EV_TICK, 4'b0001, g + 3);
    push(EV_GRANT, 4'b0000, g + 5);
    wait_until(g + 4);
    reset = 1'b1;
    wait_until(g + 5);
    check_zero("reset_in_run");
    wait_until(g + 6);
    reset = 1'b0;
    r = cyc;
    push_single(4'b0001, r + 1, 2);
    wait_until(r + 9);
    req = '0;
    wait_until(r + 12);

    // dly and other req bits changed mid-RUN are ignored.
    do_reset();
    dly[0 +: CW] = 16'd2;
    req = 4'b0001;
    g = cyc + 1;
    push_single(4'b0001, g, 2);
    wait_until(g + 2);
    dly[0 +: CW] = 16'd9;
    req = 4'b0101;
    wait_until(g + 8);
    req = '0;
    wait_until(g + 12);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
